// File: rtl/uart_host_ctrl.sv
// Bus-side controller for the uart core: TX/RX byte FIFOs, four byte-wide
// MMIO registers, a level interrupt and the initiator side of we/busy/done.
module uart_host_ctrl #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bus_addr,
    input  logic       bus_we,
    input  logic       bus_re,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq,
    output logic       uart_we,
    output logic       uart_en,
    output logic [7:0] uart_data_in,
    input  logic [7:0] uart_data_out,
    input  logic       uart_tx_busy,
    input  logic       uart_tx_done,
    input  logic       uart_rx_done
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        GAP
    } tx_state_t;

    tx_state_t state;

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    logic [PTR_W-1:0] tx_wr;
    logic [PTR_W-1:0] tx_rd;
    logic [PTR_W-1:0] rx_wr;
    logic [PTR_W-1:0] rx_rd;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;

    logic enable;
    logic rx_ie;
    logic tx_ie;
    logic rx_ovr;
    logic tx_ovf;

    logic sel_data;
    logic sel_status;
    logic sel_ctrl;
    logic tx_empty;
    logic tx_full;
    logic rx_empty;
    logic rx_full;
    logic tx_push;
    logic tx_pop;
    logic rx_push;
    logic rx_pop;
    logic tx_ovf_set;
    logic rx_ovr_set;
    logic [7:0] status_val;
    logic [7:0] level_val;

    function automatic logic [3:0] sat15(input logic [CNT_W-1:0] c);
        return (int'(c) >= 15) ? 4'hF : 4'(c);
    endfunction

    assign sel_data   = (bus_addr == 2'd0);
    assign sel_status = (bus_addr == 2'd1);
    assign sel_ctrl   = (bus_addr == 2'd2);

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);

    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign tx_pop     = (state == IDLE) & enable & ~tx_empty;
    assign tx_push    = bus_we & sel_data & (~tx_full | tx_pop);
    assign tx_ovf_set = bus_we & sel_data & tx_full & ~tx_pop;

    assign rx_pop     = bus_re & sel_data & ~rx_empty;
    assign rx_push    = uart_rx_done & (~rx_full | rx_pop);
    assign rx_ovr_set = uart_rx_done & rx_full & ~rx_pop;

    assign status_val = {1'b0, tx_ovf, rx_ovr, (state != IDLE),
                         tx_full, tx_empty, rx_full, rx_empty};
    assign level_val  = {sat15(tx_cnt), sat15(rx_cnt)};

    assign uart_en = enable;

    assign irq = (rx_ie & ~rx_empty)
               | (tx_ie & tx_empty & (state == IDLE))
               | rx_ovr
               | tx_ovf;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr] <= bus_wdata;
        end
        if (rx_push) begin
            rx_mem[rx_wr] <= uart_data_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) begin
                tx_wr <= tx_wr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + 1'b1;
            end
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) begin
                rx_wr <= rx_wr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + 1'b1;
            end
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Register file and read port; a W1C clear never beats a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= 1'b0;
            rx_ie     <= 1'b0;
            tx_ie     <= 1'b0;
            rx_ovr    <= 1'b0;
            tx_ovf    <= 1'b0;
            bus_rdata <= 8'h00;
        end else begin
            if (bus_we && sel_ctrl) begin
                {tx_ie, rx_ie, enable} <= bus_wdata[2:0];
            end
            rx_ovr <= rx_ovr_set
                    | (rx_ovr & ~(bus_we & sel_status & bus_wdata[5]));
            tx_ovf <= tx_ovf_set
                    | (tx_ovf & ~(bus_we & sel_status & bus_wdata[6]));
            if (bus_re) begin
                unique case (bus_addr)
                    2'd0: bus_rdata <= rx_empty ? 8'h00 : rx_mem[rx_rd];
                    2'd1: bus_rdata <= status_val;
                    2'd2: bus_rdata <= {5'b0, tx_ie, rx_ie, enable};
                    2'd3: bus_rdata <= level_val;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            uart_we      <= 1'b0;
            uart_data_in <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tx_pop) begin
                        state        <= REQ;
                        uart_we      <= 1'b1;
                        uart_data_in <= tx_mem[tx_rd];
                    end
                end
                REQ: begin
                    // Dropping enable before the uart accepts discards the byte.
                    if (!enable) begin
                        state   <= IDLE;
                        uart_we <= 1'b0;
                    end else if (uart_tx_busy) begin
                        state   <= WAIT;
                        uart_we <= 1'b0;
                    end
                end
                WAIT: begin
                    if (uart_tx_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (!uart_tx_busy) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed + randomized bench for uart_host_ctrl against a queue-based model
// and a simple behavioural uart responder.
module tb_uart_host_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] bus_addr;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       irq;
    logic       uart_we;
    logic       uart_en;
    logic [7:0] uart_data_in;
    logic [7:0] uart_data_out;
    logic       uart_tx_busy;
    logic       uart_tx_done;
    logic       uart_rx_done;

    uart_host_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_re        (bus_re),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .irq           (irq),
        .uart_we       (uart_we),
        .uart_en       (uart_en),
        .uart_data_in  (uart_data_in),
        .uart_data_out (uart_data_out),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_done  (uart_tx_done),
        .uart_rx_done  (uart_rx_done)
    );

    initial forever #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: plain queues and flags.
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    bit m_rx_ovr = 0;
    bit m_tx_ovf = 0;

    // Transfer monitor.
    int req_cnt = 0;
    int viol    = 0;
    logic [7:0] sent [$];
    logic we_prev   = 1'b0;
    logic busy_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    bit model_on = 0;

    function automatic logic [7:0] status_exp(input bit active);
        return {1'b0, m_tx_ovf, m_rx_ovr, active,
                txq.size() == 16, txq.size() == 0,
                rxq.size() == 16, rxq.size() == 0};
    endfunction

    function automatic logic [7:0] level_exp();
        int t;
        int r;
        t = (txq.size() > 15) ? 15 : txq.size();
        r = (rxq.size() > 15) ? 15 : rxq.size();
        return {4'(t), 4'(r)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_addr = a;
        bus_re   = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [7:0] exp);
        logic [7:0] d;
        bus_rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        uart_data_out = b;
        uart_rx_done  = 1'b1;
        @(negedge clk);
        uart_rx_done = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k;
        k = 0;
        while (!(req_cnt >= n && !uart_tx_busy && !uart_we) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_assert++;
        assert (k < 3000)
        else begin
            n_fail++;
            $error("FAIL %s observed=timeout required=%0d transfers", tag, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_we(input string tag);
        int k;
        k = 0;
        while (!uart_we && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, uart_we, 1'b1);
    endtask

    // Uart responder: busy 3 cycles after we, done 20 later, busy drops after done.
    initial begin
        uart_tx_busy = 1'b0;
        uart_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (model_on && uart_we && !uart_tx_busy) begin
                repeat (2) @(negedge clk);
                uart_tx_busy = 1'b1;
                repeat (20) @(negedge clk);
                uart_tx_done = 1'b1;
                @(negedge clk);
                uart_tx_done = 1'b0;
                uart_tx_busy = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (uart_we && uart_tx_busy && busy_prev) viol++;
        if (uart_we && we_prev && uart_data_in !== data_prev) viol++;
        if (uart_we && !we_prev) begin
            req_cnt++;
            sent.push_back(uart_data_in);
        end
        we_prev   = uart_we;
        busy_prev = uart_tx_busy;
        data_prev = uart_data_in;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        logic [7:0] e;
        logic [7:0] exp_tx [3];
        int op;
        int k;

        exp_tx = '{8'h55, 8'hA3, 8'h0F};
        rst_n = 1'b0;
        bus_addr = 2'd0;
        bus_we = 1'b0;
        bus_re = 1'b0;
        bus_wdata = 8'h00;
        uart_data_out = 8'h00;
        uart_rx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_we", uart_we, 1'b0);
        chk("rst_en", uart_en, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_data_in", uart_data_in, 8'h00);
        chk("rst_rdata", bus_rdata, 8'h00);
        rd_chk("rst_status", 2'd1, status_exp(0));
        rd_chk("rst_level", 2'd3, level_exp());

        // TX ordering and first-byte latency
        model_on = 1;
        req_cnt = 0;
        sent.delete();
        viol = 0;
        bus_wr(2'd2, 8'h01);
        chk("uart_en_on", uart_en, 1'b1);
        @(negedge clk);
        bus_addr = 2'd0;
        bus_wdata = 8'h55;
        bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0;
        chk("tx_lat1", uart_we, 1'b0);
        @(negedge clk);
        chk("tx_lat2", uart_we, 1'b1);
        chk("tx_lat2_data", uart_data_in, 8'h55);
        bus_wr(2'd0, 8'hA3);
        bus_wr(2'd0, 8'h0F);
        wait_tx(3, "tx_order_done");
        chk("req_phases", 8'(req_cnt), 8'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("tx_order_%0d", i),
                (i < sent.size()) ? sent[i] : 8'hxx, exp_tx[i]);
        end
        chk("we_busy_viol", 8'(viol), 8'd0);
        rd_chk("tx_end_status", 2'd1, status_exp(0));
        chk("tx_end_irq", irq, 1'b0);

        // TX overflow with enable off
        bus_wr(2'd2, 8'h00);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            bus_wr(2'd0, b);
            if (txq.size() < 16) txq.push_back(b);
            else m_tx_ovf = 1;
        end
        rd_chk("ovf_level", 2'd3, level_exp());
        rd_chk("ovf_status", 2'd1, status_exp(0));
        chk("ovf_irq", irq, 1'b1);
        bus_wr(2'd1, 8'h40);
        m_tx_ovf = 0;
        rd_chk("ovf_clr_status", 2'd1, status_exp(0));
        chk("ovf_clr_irq", irq, 1'b0);

        // Drain the 16 queued bytes; the dropped 17th must never appear
        req_cnt = 0;
        sent.delete();
        bus_wr(2'd2, 8'h01);
        wait_tx(16, "drain_done");
        chk("drain_count", 8'(req_cnt), 8'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i),
                (i < sent.size()) ? sent[i] : 8'hxx, txq[i]);
        end
        txq.delete();
        bus_wr(2'd2, 8'h00);
        rd_chk("drain_level", 2'd3, level_exp());

        // RX capture and overrun
        for (int i = 0; i <= 16; i++) begin
            rx_pulse(8'(i));
            if (rxq.size() < 16) rxq.push_back(8'(i));
            else m_rx_ovr = 1;
        end
        rd_chk("rx_full_level", 2'd3, level_exp());
        rd_chk("rx_full_status", 2'd1, status_exp(0));
        chk("rx_ovr_irq", irq, 1'b1);
        bus_wr(2'd1, 8'h20);
        m_rx_ovr = 0;
        rd_chk("rx_ovr_clr", 2'd1, status_exp(0));

        // Full RX FIFO: push and pop in the same cycle
        @(negedge clk);
        bus_addr = 2'd0;
        bus_re = 1'b1;
        uart_data_out = 8'h77;
        uart_rx_done = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
        uart_rx_done = 1'b0;
        e = rxq.pop_front();
        if (rxq.size() < 16) rxq.push_back(8'h77);
        else m_rx_ovr = 1;
        chk("simul_rdata", bus_rdata, e);
        rd_chk("simul_level", 2'd3, level_exp());
        rd_chk("simul_status", 2'd1, status_exp(0));
        while (rxq.size() > 0) begin
            e = rxq.pop_front();
            rd_chk("rx_drain", 2'd0, e);
        end
        rd_chk("rx_empty_read", 2'd0, 8'h00);
        rd_chk("rx_empty_status", 2'd1, status_exp(0));

        // Randomized RX traffic, reads and captures mixed
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 3);
            b = 8'($urandom);
            @(negedge clk);
            bus_addr = 2'd0;
            bus_re = (op >= 2);
            uart_data_out = b;
            uart_rx_done = (op != 2);
            @(negedge clk);
            bus_re = 1'b0;
            uart_rx_done = 1'b0;
            if (op >= 2) begin
                e = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
                chk("rand_rd", bus_rdata, e);
            end
            if (op != 2) begin
                if (rxq.size() < 16) rxq.push_back(b);
                else m_rx_ovr = 1;
            end
        end
        rd_chk("rand_level", 2'd3, level_exp());
        rd_chk("rand_status", 2'd1, status_exp(0));
        while (rxq.size() > 0) begin
            e = rxq.pop_front();
            rd_chk("rand_drain", 2'd0, e);
        end
        bus_wr(2'd1, 8'h60);
        m_rx_ovr = 0;
        m_tx_ovf = 0;
        rd_chk("flags_clr", 2'd1, status_exp(0));

        // Interrupts
        bus_wr(2'd2, 8'h02);
        chk("rx_ie_idle_irq", irq, 1'b0);
        rx_pulse(8'h3C);
        chk("rx_ie_irq", irq, 1'b1);
        rd_chk("rx_ie_data", 2'd0, 8'h3C);
        chk("rx_ie_irq_clr", irq, 1'b0);
        bus_wr(2'd2, 8'h04);
        chk("tx_ie_irq", irq, 1'b1);
        rd_chk("ctrl_read", 2'd2, 8'h04);
        bus_wr(2'd2, 8'h00);
        chk("ie_off_irq", irq, 1'b0);

        // Enable dropped during WAIT
        bus_wr(2'd0, 8'h11);
        bus_wr(2'd0, 8'h22);
        bus_wr(2'd0, 8'h33);
        txq = '{8'h11, 8'h22, 8'h33};
        req_cnt = 0;
        sent.delete();
        bus_wr(2'd2, 8'h01);
        k = 0;
        while (!uart_tx_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait_busy", uart_tx_busy, 1'b1);
        bus_wr(2'd2, 8'h00);
        wait_tx(1, "drop_done");
        repeat (10) @(negedge clk);
        chk("drop_count", 8'(req_cnt), 8'd1);
        chk("drop_byte", (sent.size() > 0) ? sent[0] : 8'hxx, 8'h11);
        void'(txq.pop_front());
        rd_chk("drop_level", 2'd3, level_exp());
        rd_chk("drop_status", 2'd1, status_exp(0));

        // Enable dropped during REQ discards the byte, then reset mid-REQ
        model_on = 0;
        bus_wr(2'd2, 8'h01);
        wait_we("req_we");
        chk("req_data", uart_data_in, 8'h22);
        bus_wr(2'd2, 8'h00);
        @(negedge clk);
        chk("req_abort_we", uart_we, 1'b0);
        void'(txq.pop_front());
        rd_chk("req_abort_level", 2'd3, level_exp());
        bus_wr(2'd2, 8'h01);
        wait_we("req2_we");
        chk("req2_data", uart_data_in, 8'h33);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", uart_we, 1'b0);
        chk("async_rst_en", uart_en, 1'b0);
        chk("async_rst_data", uart_data_in, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        txq.delete();
        rxq.delete();
        rd_chk("post_rst_status", 2'd1, status_exp(0));
        rd_chk("post_rst_level", 2'd3, level_exp());
        chk("post_rst_viol", 8'(viol), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
